i2s_adc_rx: RTL and testbench

- Receive path counterpart of the existing DAC/I2S transmit path.
- Deserialises Philips-I2S stereo ADC data from the WM8731 codec. The codec is bit-clock and LR-clock master; this block is slave.
- Presents each complete left/right sample pair on a valid/ready streaming output towards the theremin processing chain.
- Codec pins are asynchronous to clk_clk and are synchronised internally.

---
 rtl/i2s_adc_rx.sv | 160 ++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// Philips-I2S stereo ADC receiver (codec is bclk/lrck master) with a valid/ready pair output.
// Define I2S_ADC_RX_OVF_COUNT_EN to add a saturating 16-bit dropped-pair counter (ovf_count).
module i2s_adc_rx #(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic                  aud_bclk_export,
   input  logic                  aud_adclrck_export,
   input  logic                  aud_adcdat_export,
   output logic [DATA_WIDTH-1:0] left_data,
   output logic [DATA_WIDTH-1:0] right_data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  overflow,
   output logic                  sync_err
`ifdef I2S_ADC_RX_OVF_COUNT_EN
   ,
   output logic [15:0]           ovf_count
`endif
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {WAIT_LEFT, SHIFT, HOLD} state_t;

   logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
   logic                   bclk_prev, lrck_prev;
   logic                   bclk_s, lrck_s, dat_s, bclk_rise, delay_slot;

   state_t                 state, state_n;
   logic [CW-1:0]          count, count_n;
   logic [DATA_WIDTH-1:0]  shreg, shreg_n;
   logic                   channel, channel_n;
   logic                   word_done, short_err;

   logic [DATA_WIDTH-1:0]  left_hold, right_word;
   logic                   pair_done;

   assign bclk_s     = bclk_sync[SYNC_STAGES-1];
   assign lrck_s     = lrck_sync[SYNC_STAGES-1];
   assign dat_s      = dat_sync[SYNC_STAGES-1];
   assign bclk_rise  = bclk_s & ~bclk_prev;
   assign delay_slot = (lrck_s != lrck_prev);

   always_ff @(posedge clk_clk) begin
      // NOTE: every register here uses <= so all flops see pre-edge values, keeping the sync chain a true pipeline.
      if (reset_reset) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
         bclk_prev <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk_export};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_adclrck_export};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0],  aud_adcdat_export};
         bclk_prev <= bclk_s;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
      state_n   = state;
      count_n   = count;
      shreg_n   = shreg;
      channel_n = channel;
      word_done = 1'b0;
      short_err = 1'b0;
      if (bclk_rise) begin
         unique case (state)
            WAIT_LEFT: begin
               if (delay_slot && !lrck_s) begin
                  state_n   = SHIFT;
                  channel_n = 1'b0;
                  count_n   = '0;
               end
            end
            SHIFT: begin
               if (delay_slot) begin
                  short_err = 1'b1;
                  state_n   = WAIT_LEFT;
               end else begin
                  shreg_n = {shreg[DATA_WIDTH-2:0], dat_s};
                  count_n = count + 1'b1;
                  if (count == CW'(DATA_WIDTH - 1)) begin
                     word_done = 1'b1;
                     state_n   = HOLD;
                  end
               end
            end
            HOLD: begin
               if (delay_slot) begin
                  channel_n = lrck_s;
                  state_n   = SHIFT;
                  count_n   = '0;
               end
            end
            default: state_n = WAIT_LEFT;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state      <= WAIT_LEFT;
         count      <= '0;
         shreg      <= '0;
         channel    <= 1'b0;
         lrck_prev  <= 1'b0;
         left_hold  <= '0;
         right_word <= '0;
         pair_done  <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         shreg     <= shreg_n;
         channel   <= channel_n;
         pair_done <= 1'b0;
         if (bclk_rise) lrck_prev <= lrck_s;
         if (short_err) sync_err  <= 1'b1;
         if (word_done) begin
            if (!channel) begin
               left_hold <= shreg_n;
            end else begin
               right_word <= shreg_n;
               pair_done  <= 1'b1;
            end
         end
      end
   end

   // A completed pair is dropped only if the previous one is still unaccepted this cycle.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         left_data  <= '0;
         right_data <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
`ifdef I2S_ADC_RX_OVF_COUNT_EN
         ovf_count  <= '0;
`endif
      end else if (pair_done) begin
         if (valid && !ready) begin
            overflow <= 1'b1;
`ifdef I2S_ADC_RX_OVF_COUNT_EN
            if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
`endif
         end else begin
            left_data  <= left_hold;
            right_data <= right_word;
            valid      <= 1'b1;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Self-checking bench for i2s_adc_rx: I2S codec model driving frames, scoreboard of expected pairs.
module tb_i2s_adc_rx;

   localparam int DW = 16;

   typedef struct packed {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } pair_t;

   logic          clk_clk = 1'b0;
   logic          reset_reset;
   logic          bclk, lrck, dat;
   logic [DW-1:0] left_data, right_data;
   logic          valid, ready, overflow, sync_err;
`ifdef I2S_ADC_RX_OVF_COUNT_EN
   logic [15:0]   ovf_count;
`endif

   pair_t sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   int    pairs_out = 0;
   int    lsb_rise_cyc = 0;
   int    valid_rise_cyc = 0;
   logic  valid_q = 1'b0;
   logic  hs_pulse = 1'b0;
   int    p0;

   i2s_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
      .clk_clk            (clk_clk),
      .reset_reset        (reset_reset),
      .aud_bclk_export    (bclk),
      .aud_adclrck_export (lrck),
      .aud_adcdat_export  (dat),
      .left_data          (left_data),
      .right_data         (right_data),
      .valid              (valid),
      .ready              (ready),
      .overflow           (overflow),
      .sync_err           (sync_err)
`ifdef I2S_ADC_RX_OVF_COUNT_EN
      ,
      .ovf_count          (ovf_count)
`endif
   );

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Output monitor: sampled just after the falling edge, where ready already holds its value for the next edge.
   always @(negedge clk_clk) begin
      #1;
      if (valid && !valid_q) valid_rise_cyc = cyc;
      valid_q = valid;
      if (valid && ready) begin
         check("pair_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() != 0) begin
            pair_t e;
            e = sb.pop_front();
            check("left_data", {16'd0, left_data}, {16'd0, e.l});
            check("right_data", {16'd0, right_data}, {16'd0, e.r});
         end
         pairs_out++;
      end
   end

   // One bclk period (16 clk_clk) per bit; lrck/dat change with bclk low, sampled by the DUT on the rise.
   task automatic drive_bit(input logic l, input logic d, input logic is_lsb);
      bclk = 1'b0;
      lrck = l;
      dat  = d;
      repeat (8) @(negedge clk_clk);
      bclk = 1'b1;
      if (is_lsb) lsb_rise_cyc = cyc;
      if (is_lsb && hs_pulse) begin
         repeat (3) @(negedge clk_clk);
         ready = 1'b1;
         @(negedge clk_clk);
         ready = 1'b0;
         repeat (4) @(negedge clk_clk);
      end else begin
         repeat (8) @(negedge clk_clk);
      end
   endtask

   // Bit 0 is the delay slot (driven 1, must be ignored); bits past the word are random filler.
   task automatic send_slot(input logic ch, input logic [DW-1:0] word, input int nbits, input int total);
      for (int i = 0; i < total; i++) begin
         logic d;
         if (i == 0)          d = 1'b1;
         else if (i <= nbits) d = word[DW-i];
         else                 d = 1'($urandom_range(0, 1));
         drive_bit(ch, d, ch && (i == nbits));
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic push);
      pair_t p;
      p.l = l;
      p.r = r;
      if (push) sb.push_back(p);
      send_slot(1'b0, l, DW, 32);
      send_slot(1'b1, r, DW, 32);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, {31'd0, valid}, 32'd0);
      check({tag, "_left"}, {16'd0, left_data}, 32'd0);
      check({tag, "_right"}, {16'd0, right_data}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      check({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
`ifdef I2S_ADC_RX_OVF_COUNT_EN
      check({tag, "_ovf_count"}, {16'd0, ovf_count}, 32'd0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_reset = 1'b1;
      bclk  = 1'b0;
      lrck  = 1'b1;
      dat   = 1'b0;
      ready = 1'b1;
      repeat (4) @(negedge clk_clk);
      #1 check_outputs_zero("reset");
      @(negedge clk_clk);
      reset_reset = 1'b0;
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0);

      // Basic pair and output latency
      p0 = pairs_out;
      send_frame(16'h8001, 16'h7FFE, 1'b1);
      check("basic_latency", valid_rise_cyc - lsb_rise_cyc, 32'd4);
      check("basic_pairs", pairs_out - p0, 32'd1);
      check("basic_valid_low", {31'd0, valid}, 32'd0);

      // Handshake lands in the same cycle the next pair loads
      ready = 1'b0;
      send_frame(16'hA5A5, 16'h5A5A, 1'b1);
      hs_pulse = 1'b1;
      send_frame(16'h1357, 16'hFDB9, 1'b1);
      hs_pulse = 1'b0;
      check("simul_valid_held", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      repeat (4) @(negedge clk_clk);
      check("simul_overflow", {31'd0, overflow}, 32'd0);
      check("simul_sb_empty", sb.size(), 32'd0);

      // Backpressure across three frames
      ready = 1'b0;
      send_frame(16'hC0DE, 16'h0BAD, 1'b1);
      send_frame(16'h1234, 16'h5678, 1'b0);
      send_frame(16'h9ABC, 16'hDEF0, 1'b0);
      #1;
      check("bp_valid", {31'd0, valid}, 32'd1);
      check("bp_left_stable", {16'd0, left_data}, 32'h0000C0DE);
      check("bp_right_stable", {16'd0, right_data}, 32'h00000BAD);
      check("bp_overflow", {31'd0, overflow}, 32'd1);
`ifdef I2S_ADC_RX_OVF_COUNT_EN
      check("bp_ovf_count", {16'd0, ovf_count}, 32'd2);
`endif
      @(negedge clk_clk);
      ready = 1'b1;
      repeat (3) @(negedge clk_clk);
      #1 check("bp_valid_cleared", {31'd0, valid}, 32'd0);
      check("bp_sb_empty", sb.size(), 32'd0);

      // Short left word: 10 bits, then lrck toggles
      p0 = pairs_out;
      send_slot(1'b0, 16'hFFFF, 10, 11);
      send_slot(1'b1, 16'h4321, DW, 32);
      check("short_sync_err", {31'd0, sync_err}, 32'd1);
      check("short_no_pair", pairs_out - p0, 32'd0);
      send_frame(16'h0F0F, 16'hF0F0, 1'b1);
      check("short_resume_pairs", pairs_out - p0, 32'd1);

      // Reset released in the middle of a left slot
      @(negedge clk_clk);
      reset_reset = 1'b1;
      sb.delete();
      p0 = pairs_out;
      fork
         begin
            repeat (160) @(negedge clk_clk);
            reset_reset = 1'b0;
         end
      join_none
      send_slot(1'b0, 16'hABCD, DW, 32);
      send_slot(1'b1, 16'h5555, DW, 32);
      send_frame(16'h1111, 16'h2222, 1'b1);
      send_frame(16'h3333, 16'h4444, 1'b1);
      check("midstart_pairs", pairs_out - p0, 32'd2);
      check("midstart_sync_err", {31'd0, sync_err}, 32'd0);
      check("midstart_overflow", {31'd0, overflow}, 32'd0);

      // One-cycle reset while shifting a left word with a pair still pending
      ready = 1'b0;
      send_frame(16'h7777, 16'h8888, 1'b1);
      check("rst_mid_valid_before", {31'd0, valid}, 32'd1);
      fork
         begin
            repeat (128) @(negedge clk_clk);
            reset_reset = 1'b1;
            sb.delete();
            @(negedge clk_clk);
            reset_reset = 1'b0;
            #1 check_outputs_zero("rst_mid");
         end
      join_none
      send_frame(16'h6666, 16'h9999, 1'b0);
      ready = 1'b1;
      p0 = pairs_out;
      send_frame(16'hBEEF, 16'hCAFE, 1'b1);
      check("rst_mid_pairs", pairs_out - p0, 32'd1);
      check("final_sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
